// File: rtl/t01_button_queue_if.sv
// Button event stream: one event code per valid/ready transfer.
// Latency: n/a (wires only).
// Backpressure: the producer holds evt_valid/evt_code until evt_ready is sampled high.
//
// Signals:
//   evt_valid  producer -> consumer  head event available
//   evt_code   producer -> consumer  button index of the head event
//   evt_ready  consumer -> producer  head event accepted this cycle
interface t01_button_queue_if #(
  parameter int CODE_W = 2
);
  logic              evt_valid;
  logic [CODE_W-1:0] evt_code;
  logic              evt_ready;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/t01_button_queue.sv
// Turns debounced button pulses into one queued event per rising edge.
// Latency: 2 cycles from btn_in rising to evt_valid on an empty queue.
// Backpressure: full queue holds events in the pending mask; presses on an already pending button coalesce.
//
// Ports:
//   clk         system clock
//   nrst        asynchronous active-low reset
//   btn_in      debounced button levels, synchronous to clk
//   evt         event stream (master): evt_valid / evt_code out, evt_ready in
//   fifo_count  queue occupancy, 0..DEPTH
//   ovf_clr     clears the dropped flag
//   dropped     sticky coalesce flag
// Optional feature macro: T01_BTN_DROP_FLAG_EN enables the dropped flag;
// when undefined, dropped is tied low and ovf_clr is ignored.
module t01_button_queue #(
  parameter int NUM_BTN = 4,
  parameter int DEPTH   = 4,
  parameter int CODE_W  = 2,
  parameter int CNT_W   = 3
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [NUM_BTN-1:0]  btn_in,
  t01_button_queue_if.master  evt,
  output logic [CNT_W-1:0]    fifo_count,
  input  logic                ovf_clr,
  output logic                dropped
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [NUM_BTN-1:0] btn_q;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] lowest;
  logic [NUM_BTN-1:0] clr_mask;
  logic [CODE_W-1:0]  push_code;
  logic [CODE_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CODE_W-1:0]  last_code;
  logic               not_empty;
  logic               pop;
  logic               can_push;
  logic               push;
  logic               coalesce;

  assign rise      = btn_in & ~btn_q;
  assign not_empty = (count != '0);
  assign pop       = not_empty & evt.evt_ready;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign can_push  = (count != CNT_W'(DEPTH)) | pop;
  assign push      = (pending != '0) & can_push;
  assign clr_mask  = push ? lowest : '0;
  // A rise on the bit being pushed this cycle is a fresh event, not a merge.
  assign coalesce  = |(rise & pending & ~clr_mask);

  // Lowest set pending bit: scanning downward lets the last hit win.
  always_comb begin
    lowest    = '0;
    push_code = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        lowest    = '0;
        lowest[i] = 1'b1;
        push_code = CODE_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      // All ones so a button held through reset does not look like a press.
      btn_q     <= '1;
      pending   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_code <= '0;
    end else begin
      btn_q   <= btn_in;
      pending <= (pending & ~clr_mask) | rise;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        last_code <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_code;
    end
  end

  assign evt.evt_valid = not_empty;
  // Head entry while non-empty; the last popped code once drained.
  assign evt.evt_code  = not_empty ? mem[rd_ptr] : last_code;
  assign fifo_count    = count;

`ifdef T01_BTN_DROP_FLAG_EN
  logic dropped_q;

  // Coalesce takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dropped_q <= 1'b0;
    end else if (coalesce) begin
      dropped_q <= 1'b1;
    end else if (ovf_clr) begin
      dropped_q <= 1'b0;
    end
  end

  assign dropped = dropped_q;
`else
  logic unused_drop_inputs;

  assign unused_drop_inputs = ovf_clr ^ coalesce;
  assign dropped            = 1'b0;
`endif

endmodule
